// File: rtl/lab5_2_case_demux_router_if.sv
// lab5_2_case_demux_router_if: producer stream plus four consumer channels of the demux router
interface lab5_2_case_demux_router_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_bcast;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [4*CNT_W-1:0] out_cnt;
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );
endinterface

// File: rtl/lab5_2_case_demux_router.sv
// lab5_2_case_demux_router: 1-to-4 stream demux with broadcast, per-channel registered slot and delivered-beat counter
module lab5_2_case_demux_router #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  lab5_2_case_demux_router_if.slave bus
);
  logic [3:0]       can_take, one_hot, tgt, load, drain, valid;
  logic             sel_ready, accept;
  logic [WIDTH-1:0] data [4];
  logic [CNT_W-1:0] cnt [4];
  // a slot draining this cycle can be refilled in the same cycle
  assign can_take = ~valid | bus.out_ready;
  always_comb begin
    sel_ready = 1'b0;
    one_hot = 4'b0000;
    case (bus.in_sel)
      2'd0: begin sel_ready = can_take[0]; one_hot = 4'b0001; end
      2'd1: begin sel_ready = can_take[1]; one_hot = 4'b0010; end
      2'd2: begin sel_ready = can_take[2]; one_hot = 4'b0100; end
      2'd3: begin sel_ready = can_take[3]; one_hot = 4'b1000; end
      default: begin sel_ready = 1'b0; one_hot = 4'b0000; end
    endcase
  end
  assign bus.in_ready = bus.in_bcast ? &can_take : sel_ready;
  assign accept = bus.in_valid & bus.in_ready;
  assign tgt = bus.in_bcast ? 4'b1111 : one_hot;
  assign load = {4{accept}} & tgt;
  assign drain = valid & bus.out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          valid[i] <= 1'b1;
          data[i] <= bus.in_data;
        end else if (drain[i]) begin
          valid[i] <= 1'b0;
        end
        if (drain[i]) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  assign bus.out_valid = valid;
  for (genvar k = 0; k < 4; k++) begin : g_pack
    assign bus.out_data[k*WIDTH +: WIDTH] = data[k];
    assign bus.out_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end
endmodule

// File: tb/tb_lab5_2_case_demux_router.sv
// tb_lab5_2_case_demux_router: directed vector table plus hand-written reset, broadcast and streaming sequences
module tb_lab5_2_case_demux_router;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  lab5_2_case_demux_router_if #(.WIDTH(8), .CNT_W(8)) bus ();
  lab5_2_case_demux_router #(.WIDTH(8), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic       bc;
    logic [7:0] d;
    logic [3:0] rdy;
    logic       ir;
    logic [3:0] ov;
    int         ch;
    logic [7:0] cd;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic bc, input logic [7:0] d, input logic [3:0] rdy);
    bus.in_valid = v;
    bus.in_sel = sel;
    bus.in_bcast = bc;
    bus.in_data = d;
    bus.out_ready = rdy;
  endtask

  function automatic logic [7:0] chd(input int ch);
    return bus.out_data[ch*8 +: 8];
  endfunction

  function automatic logic [7:0] chc(input int ch);
    return bus.out_cnt[ch*8 +: 8];
  endfunction

  initial begin
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
    #2;
    chk("reset_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("reset_data", bus.out_data, 32'h0);
    chk("reset_cnt", bus.out_cnt, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    // sequential routing, backpressure on ch2, broadcast all-or-nothing
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 8'hAA, 4'hF, 1'b1, 4'b0001, 0, 8'hAA};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 8'hB1, 4'hF, 1'b1, 4'b0010, 1, 8'hB1};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 8'hC2, 4'hF, 1'b1, 4'b0100, 2, 8'hC2};
    tbl[3]  = '{1'b1, 2'd3, 1'b0, 8'hD3, 4'hF, 1'b1, 4'b1000, 3, 8'hD3};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 3, 8'hD3};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 8'h11, 4'hB, 1'b1, 4'b0100, 2, 8'h11};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 8'h22, 4'hB, 1'b0, 4'b0100, 2, 8'h11};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 8'h22, 4'hF, 1'b1, 4'b0100, 2, 8'h22};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 2, 8'h22};
    tbl[9]  = '{1'b1, 2'd0, 1'b1, 8'h5A, 4'h0, 1'b1, 4'b1111, 3, 8'h5A};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hD, 1'b1, 4'b0010, 1, 8'h5A};
    tbl[11] = '{1'b1, 2'd0, 1'b1, 8'h77, 4'hD, 1'b0, 4'b0010, 0, 8'h5A};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 1, 8'h5A};
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].bc, tbl[i].d, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].ir});
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), {28'd0, bus.out_valid}, {28'd0, tbl[i].ov});
      chk($sformatf("v%0d_ch%0d_data", i, tbl[i].ch), {24'd0, chd(tbl[i].ch)}, {24'd0, tbl[i].cd});
      if (i == 4) for (int c = 0; c < 4; c++) chk($sformatf("cnt_after_seq_ch%0d", c), {24'd0, chc(c)}, 32'd1);
      if (i == 9) for (int c = 0; c < 4; c++) chk($sformatf("bcast_data_ch%0d", c), {24'd0, chd(c)}, 32'h5A);
    end
    chk("cnt_final", bus.out_cnt, {8'd2, 8'd4, 8'd2, 8'd2});

    // fresh reset, then 300 back-to-back beats to ch3
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
    #2 rst_n = 1'b0;
    #1 chk("reset2_cnt", bus.out_cnt, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, 1'b0, i[7:0], 4'h8);
      #1;
      chk($sformatf("stream%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("stream%0d_valid", i), {28'd0, bus.out_valid}, 32'h8);
      chk($sformatf("stream%0d_data", i), {24'd0, chd(3)}, {24'd0, i[7:0]});
      if (i == 256) chk("stream_wrap_cnt", {24'd0, chc(3)}, 32'd0);
    end
    drive(1'b0, 2'd3, 1'b0, 8'h00, 4'h8);
    @(posedge clk); #1;
    chk("stream_drained", {28'd0, bus.out_valid}, 32'h0);
    chk("stream_cnt3", {24'd0, chc(3)}, 32'd44);

    // fill slots 0 and 1 with consumers stalled, then reset between edges
    drive(1'b1, 2'd0, 1'b0, 8'h01, 4'h0);
    @(posedge clk); #1;
    drive(1'b1, 2'd1, 1'b0, 8'h02, 4'h0);
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
    chk("stall_valid", {28'd0, bus.out_valid}, 32'h3);
    chk("stall_data", {16'd0, chd(1), chd(0)}, 32'h0201);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("midreset_cnt", bus.out_cnt, 32'h0);
    chk("midreset_data", bus.out_data, 32'h0);
    #2 rst_n = 1'b1;
    drive(1'b1, 2'd1, 1'b0, 8'h99, 4'hF);
    #1 chk("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
    chk("post_reset_valid", {28'd0, bus.out_valid}, 32'h2);
    chk("post_reset_data", {24'd0, chd(1)}, 32'h99);
    chk("post_reset_cnt", bus.out_cnt, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
